// File: rtl/badge_request_sequencer.sv
// Two-door badge swipe front end: per-door circular FIFOs, round-robin arbitration,
// and a registered single-request-per-cycle issue port toward the lab controller.
module badge_request_sequencer #(
  parameter  int DEPTH  = 4,
  parameter  int CODE_W = 5,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              reqDigital,
  input  logic [CODE_W-1:0] codeDigital,
  input  logic              dirDigital,
  input  logic              reqMera,
  input  logic [CODE_W-1:0] codeMera,
  input  logic              dirMera,
  input  logic              hold,
  input  logic              clearOverflow,
  output logic [CODE_W-1:0] smartCode,
  output logic              lab,
  output logic [1:0]        mode,
  output logic [CNT_W-1:0]  countDigital,
  output logic [CNT_W-1:0]  countMera,
  output logic              overflowDigital,
  output logic              overflowMera
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic { DOOR_DIGITAL = 1'b0, DOOR_MERA = 1'b1 } door_e;
  typedef enum logic [1:0] { MODE_EXIT = 2'b00, MODE_ENTER = 2'b01, MODE_IDLE = 2'b10 } mode_e;

  // Index 0 is the Digital door, index 1 is the Mera door.
  logic [1:0]        req;
  logic [CODE_W-1:0] code [2];
  logic [1:0]        dir;

  assign req     = {reqMera, reqDigital};
  assign code[0] = codeDigital;
  assign code[1] = codeMera;
  assign dir     = {dirMera, dirDigital};

  logic [PTR_W-1:0]  rd_ptr_q [2], rd_ptr_d [2];
  logic [PTR_W-1:0]  wr_ptr_q [2], wr_ptr_d [2];
  logic [CNT_W-1:0]  count_q  [2], count_d  [2];
  logic [1:0]        ovf_q, ovf_d;
  door_e             last_grant_q, last_grant_d;
  logic [CODE_W-1:0] smart_code_q, smart_code_d;
  logic              lab_q, lab_d;
  mode_e             mode_q, mode_d;

  // Entry layout: {code, dir}.
  logic [CODE_W:0]   mem_q [2][DEPTH];

  logic [1:0]        busy, enq, deq;
  logic              issue;
  door_e             grant;
  logic [CODE_W:0]   head;

  // NOTE: every signal driven here gets a default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    busy         = 2'b00;
    enq          = 2'b00;
    deq          = 2'b00;
    grant        = DOOR_DIGITAL;
    head         = '0;
    last_grant_d = last_grant_q;
    smart_code_d = '0;
    lab_d        = 1'b0;
    mode_d       = MODE_IDLE;
    ovf_d        = ovf_q;
    for (int i = 0; i < 2; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      count_d[i]  = count_q[i];
      busy[i]     = (count_q[i] != '0);
    end

    issue = !hold && (busy != 2'b00);

    // Tie goes to the door that did not win last time.
    if (busy == 2'b11) begin
      grant = (last_grant_q == DOOR_MERA) ? DOOR_DIGITAL : DOOR_MERA;
    end else if (busy[1]) begin
      grant = DOOR_MERA;
    end

    head   = mem_q[grant][rd_ptr_q[grant]];
    deq[0] = issue && (grant == DOOR_DIGITAL);
    deq[1] = issue && (grant == DOOR_MERA);

    if (issue) begin
      last_grant_d = grant;
      smart_code_d = head[CODE_W:1];
      lab_d        = grant;
      mode_d       = head[0] ? MODE_ENTER : MODE_EXIT;
    end

    for (int i = 0; i < 2; i++) begin
      // A full FIFO still accepts a swipe when its head leaves in the same cycle.
      enq[i] = req[i] && ((count_q[i] != CNT_W'(DEPTH)) || deq[i]);

      if (enq[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (deq[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);

      case ({enq[i], deq[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
        default: count_d[i] = count_q[i];
      endcase

      if (req[i] && !enq[i]) begin
        ovf_d[i] = 1'b1;
      end else if (clearOverflow) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_q        <= 2'b00;
      last_grant_q <= DOOR_MERA;
      smart_code_q <= '0;
      lab_q        <= 1'b0;
      mode_q       <= MODE_IDLE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      smart_code_q <= smart_code_d;
      lab_q        <= lab_d;
      mode_q       <= mode_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; counts and pointers define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (enq[i]) mem_q[i][wr_ptr_q[i]] <= {code[i], dir[i]};
    end
  end

  assign smartCode       = smart_code_q;
  assign lab             = lab_q;
  assign mode            = mode_q;
  assign countDigital    = count_q[0];
  assign countMera       = count_q[1];
  assign overflowDigital = ovf_q[0];
  assign overflowMera    = ovf_q[1];

endmodule

// File: tb/tb_badge_request_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// randomized traffic compared against a queue-based model of the swipe rules.
module tb_badge_request_sequencer;

  localparam int DEPTH  = 4;
  localparam int CODE_W = 5;
  localparam int CNT_W  = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              reqDigital = 1'b0, dirDigital = 1'b0;
  logic [CODE_W-1:0] codeDigital = '0;
  logic              reqMera = 1'b0, dirMera = 1'b0;
  logic [CODE_W-1:0] codeMera = '0;
  logic              hold = 1'b0, clearOverflow = 1'b0;
  logic [CODE_W-1:0] smartCode;
  logic              lab;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  countDigital, countMera;
  logic              overflowDigital, overflowMera;

  badge_request_sequencer #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .CLK(CLK), .RST(RST),
    .reqDigital(reqDigital), .codeDigital(codeDigital), .dirDigital(dirDigital),
    .reqMera(reqMera), .codeMera(codeMera), .dirMera(dirMera),
    .hold(hold), .clearOverflow(clearOverflow),
    .smartCode(smartCode), .lab(lab), .mode(mode),
    .countDigital(countDigital), .countMera(countMera),
    .overflowDigital(overflowDigital), .overflowMera(overflowMera)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_mode, input logic e_lab,
                           input logic [CODE_W-1:0] e_code, input logic [CNT_W-1:0] e_cd,
                           input logic [CNT_W-1:0] e_cm, input logic e_od, input logic e_om);
    check({tag, ".mode"}, 32'(mode), 32'(e_mode));
    check({tag, ".lab"}, 32'(lab), 32'(e_lab));
    check({tag, ".code"}, 32'(smartCode), 32'(e_code));
    check({tag, ".countD"}, 32'(countDigital), 32'(e_cd));
    check({tag, ".countM"}, 32'(countMera), 32'(e_cm));
    check({tag, ".ovfD"}, 32'(overflowDigital), 32'(e_od));
    check({tag, ".ovfM"}, 32'(overflowMera), 32'(e_om));
  endtask

  task automatic quiet();
    reqDigital = 1'b0; codeDigital = '0; dirDigital = 1'b0;
    reqMera = 1'b0; codeMera = '0; dirMera = 1'b0;
    hold = 1'b0; clearOverflow = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset away from a clock edge, checks the immediate effect, releases after an edge.
  task automatic do_reset(input string tag);
    quiet();
    RST = 1'b1;
    #1;
    check_all(tag, 2'b10, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic swipe_d(input logic [CODE_W-1:0] c, input logic d);
    reqDigital = 1'b1; codeDigital = c; dirDigital = d;
  endtask

  task automatic swipe_m(input logic [CODE_W-1:0] c, input logic d);
    reqMera = 1'b1; codeMera = c; dirMera = d;
  endtask

  typedef struct {
    logic              pre_rst;
    logic              rd;
    logic [CODE_W-1:0] cd;
    logic              dd;
    logic              rm;
    logic [CODE_W-1:0] cm;
    logic              dm;
    logic              hold;
    logic              clr;
    logic [1:0]        e_mode;
    logic              e_lab;
    logic [CODE_W-1:0] e_code;
    logic [CNT_W-1:0]  e_cd;
    logic [CNT_W-1:0]  e_cm;
    logic              e_od;
    logic              e_om;
  } vec_t;

  vec_t vecs [12];

  typedef logic [CODE_W:0] entry_t;
  entry_t q_d[$];
  entry_t q_m[$];

  initial begin
    #2;
    do_reset("reset0");

    //          rst rd cd        dd rm cm       dm hld clr  mode  lab code      cd cm od om
    vecs[0]  = '{1, 1, 5'b10011, 1, 0, 5'd0,  0, 0, 0, 2'b10, 0, 5'd0,      1, 0, 0, 0};
    vecs[1]  = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b01, 0, 5'b10011,  0, 0, 0, 0};
    vecs[2]  = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b10, 0, 5'd0,      0, 0, 0, 0};
    vecs[3]  = '{1, 1, 5'd3,     0, 1, 5'd7,  1, 0, 0, 2'b10, 0, 5'd0,      1, 1, 0, 0};
    vecs[4]  = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b00, 0, 5'd3,      0, 1, 0, 0};
    vecs[5]  = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b01, 1, 5'd7,      0, 0, 0, 0};
    vecs[6]  = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b10, 0, 5'd0,      0, 0, 0, 0};
    vecs[7]  = '{0, 1, 5'd1,     1, 1, 5'd2,  0, 0, 0, 2'b10, 0, 5'd0,      1, 1, 0, 0};
    vecs[8]  = '{0, 1, 5'd4,     1, 1, 5'd6,  1, 0, 0, 2'b01, 0, 5'd1,      1, 2, 0, 0};
    vecs[9]  = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b00, 1, 5'd2,      1, 1, 0, 0};
    vecs[10] = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b01, 0, 5'd4,      0, 1, 0, 0};
    vecs[11] = '{0, 0, 5'd0,     0, 0, 5'd0,  0, 0, 0, 2'b01, 1, 5'd6,      0, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].pre_rst) do_reset($sformatf("vec%0d.rst", i));
      reqDigital = vecs[i].rd; codeDigital = vecs[i].cd; dirDigital = vecs[i].dd;
      reqMera = vecs[i].rm; codeMera = vecs[i].cm; dirMera = vecs[i].dm;
      hold = vecs[i].hold; clearOverflow = vecs[i].clr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_mode, vecs[i].e_lab, vecs[i].e_code,
                vecs[i].e_cd, vecs[i].e_cm, vecs[i].e_od, vecs[i].e_om);
    end
    quiet();

    // Hold while five Mera swipes arrive: the fifth is dropped, then release drains in order.
    do_reset("hold.rst");
    for (int i = 0; i < 5; i++) begin
      quiet();
      hold = 1'b1;
      swipe_m(CODE_W'(10 + i), 1'(i % 2));
      tick();
      check_all($sformatf("hold.fill%0d", i), 2'b10, 1'b0, '0, '0,
                CNT_W'((i < 4) ? i + 1 : 4), 1'b0, 1'(i == 4));
    end
    quiet();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("hold.drain%0d", i), {1'b0, 1'(i % 2)}, 1'b1, CODE_W'(10 + i),
                '0, CNT_W'(3 - i), 1'b0, 1'b1);
    end
    tick();
    check_all("hold.after", 2'b10, 1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Full Digital FIFO accepts a swipe in the cycle its head is popped.
    do_reset("full.rst");
    for (int i = 0; i < 4; i++) begin
      quiet();
      hold = 1'b1;
      swipe_d(CODE_W'(1 + i), 1'b1);
      tick();
    end
    check("full.count", 32'(countDigital), 32'd4);
    quiet();
    swipe_d(5'd9, 1'b0);
    tick();
    check_all("full.popin", 2'b01, 1'b0, 5'd1, 3'd4, '0, 1'b0, 1'b0);
    quiet();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("full.drain%0d", i), (i == 3) ? 2'b00 : 2'b01, 1'b0,
                (i == 3) ? 5'd9 : CODE_W'(2 + i), CNT_W'(3 - i), '0, 1'b0, 1'b0);
    end

    // Set beats clear when both happen in the same cycle; clear alone then wins.
    do_reset("clr.rst");
    for (int i = 0; i < 5; i++) begin
      quiet();
      hold = 1'b1;
      swipe_d(CODE_W'(i), 1'b1);
      tick();
    end
    check("clr.ovf_set", 32'(overflowDigital), 32'd1);
    quiet();
    hold = 1'b1;
    clearOverflow = 1'b1;
    swipe_d(5'd20, 1'b1);
    tick();
    check("clr.set_wins", 32'(overflowDigital), 32'd1);
    quiet();
    hold = 1'b1;
    clearOverflow = 1'b1;
    tick();
    check_all("clr.alone", 2'b10, 1'b0, '0, 3'd4, '0, 1'b0, 1'b0);

    // Reset mid-operation with three queued entries discards them.
    do_reset("rst.pre");
    for (int i = 0; i < 3; i++) begin
      quiet();
      hold = 1'b1;
      swipe_d(CODE_W'(21 + i), 1'b1);
      tick();
    end
    quiet();
    tick();
    check_all("rst.issuing", 2'b01, 1'b0, 5'd21, 3'd2, '0, 1'b0, 1'b0);
    do_reset("rst.mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("rst.after%0d", i), 2'b10, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    end

    // Randomized traffic against a queue model of the swipe rules.
    do_reset("rand.rst");
    begin
      logic last_mera = 1'b1;
      logic m_od = 1'b0, m_om = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        logic [1:0]        e_mode;
        logic              e_lab;
        logic [CODE_W-1:0] e_code;
        entry_t            e;
        logic              take_m;
        reqDigital    = 1'($urandom_range(0, 1));
        codeDigital   = CODE_W'($urandom_range(0, 31));
        dirDigital    = 1'($urandom_range(0, 1));
        reqMera       = 1'($urandom_range(0, 1));
        codeMera      = CODE_W'($urandom_range(0, 31));
        dirMera       = 1'($urandom_range(0, 1));
        hold          = ($urandom_range(0, 3) == 0);
        clearOverflow = ($urandom_range(0, 9) == 0);

        e_mode = 2'b10; e_lab = 1'b0; e_code = '0;
        if (!hold && (q_d.size() + q_m.size() > 0)) begin
          if (q_d.size() > 0 && q_m.size() > 0) take_m = !last_mera;
          else take_m = (q_m.size() > 0);
          e = take_m ? q_m.pop_front() : q_d.pop_front();
          last_mera = take_m;
          e_mode = {1'b0, e[0]};
          e_lab  = take_m;
          e_code = e[CODE_W:1];
        end
        if (reqDigital && q_d.size() >= DEPTH) m_od = 1'b1;
        else begin
          if (reqDigital) q_d.push_back({codeDigital, dirDigital});
          if (clearOverflow) m_od = 1'b0;
        end
        if (reqMera && q_m.size() >= DEPTH) m_om = 1'b1;
        else begin
          if (reqMera) q_m.push_back({codeMera, dirMera});
          if (clearOverflow) m_om = 1'b0;
        end

        tick();
        check_all($sformatf("rand%0d", cyc), e_mode, e_lab, e_code,
                  CNT_W'(q_d.size()), CNT_W'(q_m.size()), m_od, m_om);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/badge_request_sequencer.md
# badge_request_sequencer

Front-end stage between the two door card readers (Digital, Mera) and the lab access controller. Each reader delivers enter/exit swipes as one-cycle strobes at any time. The sequencer buffers them in per-door FIFOs, arbitrates round-robin, and emits at most one request per cycle on the controller's `smartCode` / `lab` / `mode` interface. Cycles with no request are filled with idle.

## Interface
- `DEPTH`, 4: entries per door FIFO; power of two, ≥2.
- `CODE_W`, 5: smart-card code width.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-high reset.
- `reqDigital`  in  1  one-cycle swipe strobe, Digital door.
- `codeDigital`  in  CODE_W  card code, valid with `reqDigital`.
- `dirDigital`  in  1  1 = enter, 0 = exit.
- `reqMera` / `codeMera` / `dirMera`: same as the Digital three, for the Mera door.
- `hold`  in  1  1 = issue nothing this cycle; FIFOs keep filling.
- `clearOverflow`  in  1  clears both overflow flags.
- `smartCode`  out  CODE_W  registered; code of the issued request.
- `lab`  out  1  registered; 0 = Digital, 1 = Mera.
- `mode`  out  2  registered; 00 = exit, 01 = enter, 10 = idle.
- `countDigital`, `countMera`  out  log2(DEPTH)+1  registered FIFO occupancy.
- `overflowDigital`, `overflowMera`  out  1  sticky dropped-swipe flags.

## Operation
- Each door has a circular FIFO of {code, dir} with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Enqueue: if `req*` = 1, the entry is written when count < DEPTH, or when count = DEPTH and that same FIFO is dequeued this cycle.
- Overflow: otherwise the swipe is dropped and the door's overflow flag is set. Count and pointers are unchanged.
- Issue eligibility: issue happens only when `hold` = 0 and at least one FIFO is non-empty.
- Grant selection:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: grant the door opposite `lastGrant`.
  - `lastGrant` updates on every issue.
- Issue outputs: `smartCode` = head code, `lab` = granted door, `mode` = {1'b0, dir}. The head is popped.
- No issue (hold, or both FIFOs empty): `mode` = 10, `smartCode` = 0, `lab` = 0.
- Outputs are rewritten every cycle. An issued request is present for exactly one cycle.
- Count arithmetic per FIFO: count + enq − deq. Simultaneous enq and deq leaves count unchanged.
- Count saturation: count never exceeds DEPTH and never underflows.
- `clearOverflow` and a new overflow in the same cycle: the flag ends at 1 (set wins).
- Both doors strobing in the same cycle: both are enqueued independently.

## Timing
- Reset (async, immediate) values:
  - `mode` = 10; `smartCode` = 0; `lab` = 0.
  - Counts = 0; pointers = 0; overflow flags = 0.
  - `lastGrant` = Mera, so Digital wins the first tie.
- Assertion of `RST` mid-operation discards all queued swipes. The first edge after deassertion operates normally.
- Latency: a swipe sampled at edge N is written at edge N. The earliest it can appear on the outputs is after edge N+1. There is no bypass path.
- Throughput: one request per cycle sustained. Two always-busy doors alternate D, M, D, M.
- `hold` is sampled at each edge. Asserting it at edge N makes the outputs after edge N idle. Queued order is preserved.
- No backpressure to the readers. Loss is reported only through the overflow flags.

## Test plan
- Reset, then a single Digital swipe (code 5'b10011, enter) at edge 1 → after edge 2: `mode` = 01, `lab` = 0, `smartCode` = 10011. After edge 3: `mode` = 10 and `countDigital` = 0.
- Both doors strobe together at edge 1 (Digital exit code 3, Mera enter code 7) → after edge 2: Digital, mode 00, code 3. After edge 3: Mera, mode 01, code 7.
- `hold` = 1 while 5 Mera swipes arrive (DEPTH = 4) → `countMera` = 4 and `overflowMera` = 1. The 5th swipe is lost. Releasing `hold` issues 4 requests in arrival order on consecutive cycles.
- Full Digital FIFO, `hold` = 0, new swipe in the same cycle as a pop → swipe accepted, `countDigital` stays 4, `overflowDigital` stays 0.
- `clearOverflow` in the same cycle as an overflowing swipe → flag stays 1. `clearOverflow` alone on the next cycle → flag 0.
- `RST` pulsed with 3 entries queued → outputs immediately idle and counts 0. No stale request is issued after reset releases.
